serial_det_arbiter: RTL

Round-robin arbiter and sequencer that shares one serial sequence-detector instance (single-bit `x_in` → `y_out`, detector reset active-low) between N requesters. Each granted requester hands over a parallel word; the block clears the detector, shifts the word into it MSB-first, and collects the per-bit detector output into a hit mask and hit count. It returns that result to the requester with a one-cycle done pulse. It sits between the requester logic and the shared detector, and owns the detector's `x_in` and reset pins exclusively.

---
 rtl/serial_det_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/serial_det_arbiter.sv
// Round-robin sequencer sharing one serial sequence detector between N_REQ requesters.
// Each grant clears the detector, shifts a word in MSB-first and returns the hit mask/count.
module serial_det_arbiter #(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 4,
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*WORD_W-1:0]   data_in,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic                      det_reset_n,
    output logic                      x_out,
    input  logic                      y_in,
    output logic                      done,
    output logic [ID_W-1:0]           done_id,
    output logic [CNT_W-1:0]          hit_count,
    output logic [WORD_W-1:0]         hit_mask
);

    localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_nxt;
    logic [ID_W-1:0]     ptr_q, ptr_nxt;
    logic [ID_W-1:0]     sel_q, sel_nxt;
    logic [WORD_W-1:0]   sreg_q, sreg_nxt;
    logic [BIT_W-1:0]    bit_q, bit_nxt;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_nxt;
    logic [WORD_W-1:0]   acc_mask_q, acc_mask_nxt;

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     cand;
    logic                bit_last;

    logic [N_REQ-1:0]    gnt_nxt;
    logic                busy_nxt;
    logic                det_reset_n_nxt;
    logic                x_out_nxt;
    logic                done_nxt;
    logic [ID_W-1:0]     done_id_nxt;
    logic [CNT_W-1:0]    hit_count_nxt;
    logic [WORD_W-1:0]   hit_mask_nxt;

    assign bit_last = (bit_q == BIT_W'(WORD_W - 1));

    // Round-robin pick: first set request searching upward from ptr+1.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(ptr_q) + k) % N_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (pick_found) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_SHIFT;
            ST_SHIFT: if (bit_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs.
    always_comb begin
        ptr_nxt       = ptr_q;
        sel_nxt       = sel_q;
        sreg_nxt      = sreg_q;
        bit_nxt       = bit_q;
        acc_cnt_nxt   = acc_cnt_q;
        acc_mask_nxt  = acc_mask_q;
        done_nxt      = 1'b0;
        done_id_nxt   = done_id;
        hit_count_nxt = hit_count;
        hit_mask_nxt  = hit_mask;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    sel_nxt      = pick_idx;
                    sreg_nxt     = data_in[32'(pick_idx)*WORD_W +: WORD_W];
                    bit_nxt      = '0;
                    acc_cnt_nxt  = '0;
                    acc_mask_nxt = '0;
                end
            end
            ST_SHIFT: begin
                sreg_nxt     = {sreg_q[WORD_W-2:0], 1'b0};
                bit_nxt      = bit_q + BIT_W'(1);
                acc_mask_nxt = {acc_mask_q[WORD_W-2:0], y_in};
                acc_cnt_nxt  = acc_cnt_q + CNT_W'(y_in);
                if (bit_last) begin
                    done_nxt      = 1'b1;
                    done_id_nxt   = sel_q;
                    hit_count_nxt = acc_cnt_nxt;
                    hit_mask_nxt  = acc_mask_nxt;
                end
            end
            ST_DONE: ptr_nxt = sel_q;
            default: ;
        endcase

        gnt_nxt         = (state_nxt == ST_IDLE) ? '0 : (N_REQ'(1) << sel_nxt);
        busy_nxt        = (state_nxt != ST_IDLE);
        det_reset_n_nxt = (state_nxt != ST_CLEAR);
        x_out_nxt       = (state_nxt == ST_SHIFT) && sreg_nxt[WORD_W-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q       <= ID_W'(N_REQ - 1);
            sel_q       <= '0;
            sreg_q      <= '0;
            bit_q       <= '0;
            acc_cnt_q   <= '0;
            acc_mask_q  <= '0;
            gnt         <= '0;
            busy        <= 1'b0;
            det_reset_n <= 1'b0;
            x_out       <= 1'b0;
            done        <= 1'b0;
            done_id     <= '0;
            hit_count   <= '0;
            hit_mask    <= '0;
        end else begin
            ptr_q       <= ptr_nxt;
            sel_q       <= sel_nxt;
            sreg_q      <= sreg_nxt;
            bit_q       <= bit_nxt;
            acc_cnt_q   <= acc_cnt_nxt;
            acc_mask_q  <= acc_mask_nxt;
            gnt         <= gnt_nxt;
            busy        <= busy_nxt;
            det_reset_n <= det_reset_n_nxt;
            x_out       <= x_out_nxt;
            done        <= done_nxt;
            done_id     <= done_id_nxt;
            hit_count   <= hit_count_nxt;
            hit_mask    <= hit_mask_nxt;
        end
    end

endmodule
